uart_receiver: RTL

//   Serial-to-parallel UART receive stage: the link-side counterpart of the transmit path.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_receiver_if.sv | 25 ++
 rtl/uart_sync_2ff.sv | 25 ++
 rtl/uart_receiver.sv | 126 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and receive FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Consumer-side handshake and status bundle of the UART receiver.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;

  // Receiver side: produces bytes and status, takes the ack.
  modport master (
    output rx_data, rx_valid, frame_err, overrun, rx_busy,
    input  rx_ack
  );

  // Consumer side: reads bytes and status, issues the ack.
  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-stage synchronizer for an asynchronous single-bit input.
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic sync_reg;

  // Shift the async input through two flops; reset to the line's idle level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start detection, mid-bit sampling,
// valid/ack byte handoff with framing-error pulse and sticky overrun.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_tick,
  input  logic            rxd,
  uart_receiver_if.master rx_if
);
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_t          state_reg;
  logic [TICK_W-1:0]    tick_cnt_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;
  logic                 rx_s;

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rx_s)
  );

  // Receive FSM plus output registers; all line decisions happen on br_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;

      // Ack consumes the held byte; a completion later in this block
      // overrides rx_valid so a same-clock ack never raises overrun.
      if (rx_if.rx_ack && rx_valid_reg) begin
        rx_valid_reg <= 1'b0;
        overrun_reg  <= 1'b0;
      end

      if (br_tick) begin
        case (state_reg)
          ST_IDLE: begin
            if (!rx_s) begin
              state_reg    <= ST_START;
              tick_cnt_reg <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt_reg == TICK_HALF) begin
              tick_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              // A line that is high again at mid start bit was a glitch.
              state_reg    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick_cnt_reg == TICK_LAST) begin
              shift_reg    <= {rx_s, shift_reg[DATA_BITS-1:1]};
              tick_cnt_reg <= '0;
              bit_cnt_reg  <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == BIT_LAST) begin
                state_reg <= ST_STOP;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          ST_STOP: begin
            if (tick_cnt_reg == TICK_LAST) begin
              tick_cnt_reg <= '0;
              if (rx_s) begin
                rx_data_reg  <= shift_reg;
                rx_valid_reg <= 1'b1;
                if (rx_valid_reg && !rx_if.rx_ack) begin
                  overrun_reg <= 1'b1;
                end
                state_reg <= ST_IDLE;
              end else begin
                frame_err_reg <= 1'b1;
                state_reg     <= ST_WAIT_HIGH;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          ST_WAIT_HIGH: begin
            // Hold off until the line returns idle so a break is not a start.
            if (rx_s) begin
              state_reg <= ST_IDLE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_if.rx_data   = rx_data_reg;
  assign rx_if.rx_valid  = rx_valid_reg;
  assign rx_if.frame_err = frame_err_reg;
  assign rx_if.overrun   = overrun_reg;
  assign rx_if.rx_busy   = (state_reg != ST_IDLE);
endmodule
